// File: rtl/cfg_sequencer.sv
// cfg_sequencer: byte-command sequencer for register bursts and oscillator init/step; optional WRITE watchdog via CFG_SEQ_WATCHDOG_EN
module cfg_sequencer #(
  parameter int WD_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic [2:0] addr,
  output logic [7:0] wdata,
  output logic       load,
  output logic       osc_init,
  output logic       osc_step,
  output logic       busy,
  output logic       err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_INIT  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  logic [1:0] state, state_n;
  logic [2:0] cur, cur_n;
  logic [2:0] rem, rem_n;
  logic [2:0] addr_n;
  logic [5:0] div, div_n;
  logic [5:0] cnt, cnt_n;
  logic [7:0] wdata_n;
  logic       err_n;
  logic       load_n;
  logic       step_n;
  logic       wd_fire;
  logic       acc;
  logic [1:0] op;
  logic [2:0] hdr_a;
  logic       a_ok;
  assign acc   = byte_valid && byte_ready;
  assign op    = byte_data[7:6];
  assign hdr_a = byte_data[5:3];
  assign a_ok  = hdr_a >= 3'd2 && hdr_a <= 3'd6;
`ifdef CFG_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WD_LIMIT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WD_LIMIT - 1);
  logic [WW-1:0] wd;
  assign wd_fire = state == S_WRITE && !acc && wd == WD_LAST;
  // count consecutive WRITE cycles without a data byte; zero everywhere else
  always_ff @(posedge clk or posedge reset)
    if (reset)
      wd <= '0;
    else
      wd <= (state == S_WRITE && !acc && !wd_fire) ? wd + 1'b1 : '0;
`else
  logic unused_wd;
  assign unused_wd = ^WD_LIMIT;
  assign wd_fire   = 1'b0;
`endif
  // step enable for the coming cycle: counter at zero while staying in RUN
  assign step_n = state_n == S_RUN && cnt_n == 6'd0;
  // decode accepted bytes into next state, burst bookkeeping and error flag
  always_comb begin
    state_n = state;
    cur_n   = cur;
    rem_n   = rem;
    div_n   = div;
    cnt_n   = cnt;
    err_n   = err;
    addr_n  = 3'd0;
    wdata_n = wdata;
    load_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc) begin
          case (op)
            OP_WRITE: begin
              state_n = a_ok ? S_WRITE : S_IDLE;
              err_n   = a_ok ? err : 1'b1;
              cur_n   = hdr_a;
              rem_n   = byte_data[2:0];
            end
            OP_RUN: begin
              state_n = S_INIT;
              div_n   = byte_data[5:0];
            end
            OP_STOP: err_n = 1'b0;
            default: err_n = 1'b1;
          endcase
        end
      end
      S_WRITE: begin
        if (acc) begin
          load_n  = 1'b1;
          addr_n  = cur;
          wdata_n = byte_data;
          cur_n   = (cur == 3'd6) ? 3'd2 : cur + 3'd1;
          rem_n   = rem - 3'd1;
          state_n = (rem == 3'd0) ? S_IDLE : S_WRITE;
        end else if (wd_fire) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_INIT: begin
        state_n = S_RUN;
        cnt_n   = div;
      end
      default: begin
        cnt_n = (cnt == 6'd0) ? div : cnt - 6'd1;
        if (acc) begin
          case (op)
            OP_RUN: begin
              div_n = byte_data[5:0];
              cnt_n = byte_data[5:0];
            end
            OP_STOP: begin
              state_n = S_IDLE;
              err_n   = 1'b0;
            end
            default: err_n = 1'b1;
          endcase
        end
      end
    endcase
  end
  // register state and every output so all outputs come straight from flops
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= S_IDLE;
      cur        <= 3'd0;
      rem        <= 3'd0;
      div        <= 6'd0;
      cnt        <= 6'd0;
      byte_ready <= 1'b0;
      addr       <= 3'd0;
      wdata      <= 8'd0;
      load       <= 1'b0;
      osc_init   <= 1'b0;
      osc_step   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      rem        <= rem_n;
      div        <= div_n;
      cnt        <= cnt_n;
      byte_ready <= state_n != S_INIT;
      addr       <= addr_n;
      wdata      <= wdata_n;
      load       <= load_n;
      osc_init   <= state_n == S_INIT;
      osc_step   <= step_n;
      busy       <= state_n != S_IDLE;
      err        <= err_n;
    end
endmodule

// File: tb/tb_cfg_sequencer.sv
// tb_cfg_sequencer: scoreboard bench with randomized command streams against a cycle-stamped event model
module tb_cfg_sequencer;
  localparam int WDL = 20;
  typedef struct {int c; logic [2:0] a; logic [7:0] d;} ld_t;
  logic       clk = 0;
  logic       reset = 1;
  logic       byte_valid = 0;
  logic [7:0] byte_data = 0;
  logic       byte_ready;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       load;
  logic       osc_init;
  logic       osc_step;
  logic       busy;
  logic       err;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ns = 0;
  int p = 1;
  logic exp_err = 0;
  logic exp_busy = 0;
  logic mon_on = 0;
  ld_t load_q[$];
  int  init_q[$];
  int  step_q[$];
  cfg_sequencer #(.WD_LIMIT(WDL)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .addr(addr), .wdata(wdata), .load(load),
    .osc_init(osc_init), .osc_step(osc_step), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && mon_on) begin
      chk("err", err, exp_err);
      chk("busy", busy, exp_busy);
      if (load) begin
        chk("load_expected", load_q.size() > 0, 1);
        if (load_q.size() > 0) begin
          ld_t ev;
          ev = load_q.pop_front();
          chk("load_cycle", cyc + 1, ev.c);
          chk("load_addr", addr, ev.a);
          chk("load_wdata", wdata, ev.d);
        end
      end else
        chk("addr_when_no_load", addr, 0);
      if (osc_init) begin
        chk("init_expected", init_q.size() > 0, 1);
        chk("ready_low_in_init", byte_ready, 0);
        if (init_q.size() > 0) chk("init_cycle", cyc + 1, init_q.pop_front());
      end
      if (osc_step) begin
        chk("step_expected", step_q.size() > 0, 1);
        if (step_q.size() > 0) chk("step_cycle", cyc + 1, step_q.pop_front());
      end
    end
  end
  task automatic idle_until(input int t);
    byte_valid = 0;
    while (cyc < t - 1) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b, output int e);
    @(negedge clk);
    for (int i = 0; i < 50 && !byte_ready; i++) @(negedge clk);
    if (!byte_ready) begin
      chk("byte_ready_wait", byte_ready, 1);
      e = -1;
      return;
    end
    byte_valid = 1;
    byte_data  = b;
    @(posedge clk);
    #1;
    byte_valid = 0;
    e = cyc;
  endtask
  task automatic push_steps(input int lim);
    while (ns <= lim) begin
      step_q.push_back(ns);
      ns += p;
    end
  endtask
  task automatic do_write(input logic [7:0] hdr, input int gmax);
    int e;
    int a;
    int n;
    logic [7:0] b;
    send(hdr, e);
    a = int'(hdr[5:3]);
    n = int'(hdr[2:0]) + 1;
    if (a < 2 || a > 6) begin
      exp_err = 1;
      return;
    end
    exp_busy = 1;
    for (int i = 0; i < n; i++) begin
      idle_until(e + 1 + int'($urandom_range(gmax, 0)));
      b = 8'($urandom);
      send(b, e);
      load_q.push_back('{e + 1, 3'(2 + (a - 2 + i) % 5), b});
    end
    exp_busy = 0;
  endtask
  task automatic run_sess(input logic [5:0] d, input int mk, input logic [5:0] d2, input int t_mid, input int t_stop);
    int e0;
    int e;
    int r;
    int m;
    send({2'b01, d}, e0);
    init_q.push_back(e0 + 1);
    exp_busy = 1;
    ns = e0 + 2 + int'(d);
    p  = int'(d) + 1;
    r  = e0 + 1;
    if (mk != 0) begin
      r = e0 + 2 + t_mid;
      push_steps(r);
      idle_until(r);
      send(mk == 1 ? {2'b01, d2} : mk == 2 ? {2'b00, d2} : {2'b11, d2}, e);
      chk("mid_accept_edge", e, r);
      if (mk == 1) begin
        ns = r + 1 + int'(d2);
        p  = int'(d2) + 1;
      end else
        exp_err = 1;
    end
    m = r + t_stop;
    push_steps(m);
    idle_until(m);
    send(8'h80, e);
    chk("stop_accept_edge", e, m);
    exp_busy = 0;
    exp_err  = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int e;
    int k;
    #3;
    chk("reset_outputs", {byte_ready, addr, wdata, load, osc_init, osc_step, busy, err}, 0);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", byte_ready, 1);
    mon_on = 1;
    do_write(8'h13, 0);
    do_write(8'h31, 0);
    do_write(8'h00, 0);
    send(8'h80, e);
    exp_err = 0;
    run_sess(6'd2, 0, 6'd0, 0, 12);
    run_sess(6'd0, 2, 6'h11, 3, 6);
    send(8'h17, e);
    exp_busy = 1;
    for (int i = 0; i < 2; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send(b, e);
      load_q.push_back('{e + 1, 3'(2 + i), b});
    end
    @(negedge clk);
    #2;
    reset = 1;
    exp_busy = 0;
    exp_err  = 0;
    #1;
    chk("async_reset_outputs", {byte_ready, addr, wdata, load, osc_init, osc_step, busy, err}, 0);
    @(negedge clk);
    reset = 0;
    chk("ready_before_first_edge", byte_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_release", byte_ready, 1);
    run_sess(6'd0, 0, 6'd0, 0, 5);
`ifdef CFG_SEQ_WATCHDOG_EN
    send(8'h10, e);
    exp_busy = 1;
    idle_until(e + WDL);
    exp_err  = 1;
    exp_busy = 0;
    idle_until(e + WDL + 3);
    send(8'h80, e);
    exp_err = 0;
`endif
    for (int t = 0; t < 40; t++) begin
      k = int'($urandom_range(4, 0));
      if (k <= 1)
        do_write({2'b00, 6'($urandom)}, 3);
      else if (k == 2)
        run_sess(6'($urandom_range(7, 0)), int'($urandom_range(3, 0)), 6'($urandom_range(5, 0)),
                 int'($urandom_range(12, 0)), int'($urandom_range(25, 1)));
      else if (k == 3) begin
        send(8'h80, e);
        exp_err = 0;
      end else begin
        send({2'b11, 6'($urandom)}, e);
        exp_err = 1;
      end
    end
    idle_until(cyc + 5);
    chk("loads_left", load_q.size(), 0);
    chk("inits_left", init_q.size(), 0);
    chk("steps_left", step_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cfg_sequencer.md
# cfg_sequencer

Byte-stream controller that sits between the chip's input pins and the oscillator register bank and core. It decodes a simple command protocol, sequences burst writes into register addresses 2–6 with auto-increment, and issues the oscillator `osc_init` pulse. It then generates periodic `osc_step` enables until it receives a stop command.

## Interface
Parameters:
- `WD_LIMIT`, default 255: watchdog timeout in cycles. Only used with `CFG_SEQ_WATCHDOG_EN`.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `byte_valid` in 1: an input byte is offered.
- `byte_data` in 8: the offered byte.
- `byte_ready` out 1: the block can accept a byte. A transfer occurs when `byte_valid && byte_ready`.
- `addr` out 3: register address. It is 0 (read mode) whenever `load` is low.
- `wdata` out 8: register write data.
- `load` out 1: register write strobe, one cycle per data byte.
- `osc_init` out 1: one-cycle pulse that copies init_re/init_im into the oscillator accumulator.
- `osc_step` out 1: one-cycle enable for each oscillator iteration.
- `busy` out 1: the block is in a state other than IDLE.
- `err` out 1: sticky protocol error flag.

## Operation
- All outputs are registered. Reset values: `byte_ready`=0, `addr`=0, `wdata`=0, `load`=0, `osc_init`=0, `osc_step`=0, `busy`=0, `err`=0. The state is IDLE.
- The first clock edge after reset deasserts sets `byte_ready`=1.
- Header byte opcode, `byte_data[7:6]`:
  - 00 WRITE: `[5:3]` is the start address `a`; `[2:0]` is the count−1 (1..8 bytes).
  - 01 RUN: `[5:0]` is the step divider `d`.
  - 10 STOP.
  - 11 is reserved and sets `err`.
- States: IDLE, WRITE, INIT, RUN.
- IDLE:
  - WRITE header with `a` in 2..6 → WRITE.
  - WRITE header with `a` outside 2..6 → set `err`, stay in IDLE.
  - RUN header → INIT.
  - STOP header → clear `err`, stay in IDLE.
  - Reserved opcode → set `err`, stay in IDLE.
- WRITE:
  - Each accepted byte is a data byte, not a header.
  - The cycle after acceptance: `load`=1, `addr`=current address, `wdata`=byte.
  - The address then increments, wrapping 6→2.
  - After the last of the count bytes → IDLE.
- INIT:
  - `osc_init`=1 for exactly one cycle, with `byte_ready`=0.
  - The step counter is loaded with `d`, then the state goes to RUN.
- RUN:
  - The counter decrements each cycle.
  - When the counter is 0: `osc_step`=1 that cycle and the counter reloads `d`.
  - Accepted headers in RUN:
    - STOP → IDLE. No further `osc_step` after the cycle of acceptance.
    - RUN → reload divider `d`, no new `osc_init`.
    - WRITE → set `err`, ignore the header, keep running.
    - Reserved → set `err`, keep running.
- `err` is cleared only by `reset` or an accepted STOP header, in any state. Setting and clearing on the same byte cannot happen.
- `busy` = (state != IDLE).

## Timing
- Header accepted at edge N: the state changes at edge N.
- WRITE data byte accepted at edge N: `load`/`addr`/`wdata` are valid in cycle N+1 only. Back-to-back bytes therefore give consecutive `load` pulses.
- RUN header accepted at edge N: `osc_init` is high during cycle N+1. The first `osc_step` is high in cycle N+2+d, and subsequent ones every d+1 cycles. With d=0, `osc_step` is continuously high from N+2.
- `byte_ready` is low only during INIT. It is high in IDLE, WRITE and RUN.
- STOP accepted at edge N in RUN: `osc_step` is 0 from cycle N+1 onward, even if the counter hit 0 that cycle.
- Reset asserted mid-burst or mid-run: all outputs go to reset values immediately, without waiting for a clock. A partially written burst is abandoned; registers already written keep their values.

## Configuration
- `CFG_SEQ_WATCHDOG_EN` defined:
  - In WRITE, an idle counter counts cycles with no accepted byte.
  - On reaching `WD_LIMIT`: set `err`, → IDLE, no `load` issued.
  - The counter clears on each accepted byte and on entry to WRITE.
- Not defined: WRITE waits indefinitely for data bytes. `WD_LIMIT` has no effect.

## Test plan
- Burst write: header 0x13 (a=2, count 4), then bytes 0x11,0x22,0x33,0x44 back-to-back → four consecutive `load` pulses with addr 2,3,4,5 and matching `wdata`. Then IDLE, `busy`=0, `addr`=0.
- Wrap: header 0x31 (a=6, count 2), then 0xAA,0xBB → writes at addr 6 then 2.
- Bad start address: header 0x00 (a=0) → `err`=1, no `load`, state IDLE. Then header 0x80 → `err`=0.
- Run: header 0x42 (d=2) accepted at edge N → `osc_init` in cycle N+1, `osc_step` in cycles N+4, N+7, N+10, …. Then STOP → no further `osc_step`, `busy`=0.
- Write during RUN: RUN d=0, then header 0x11 → `err`=1, `osc_step` continues every cycle, no `load`.
- Reset mid-burst: header 0x17, two data bytes, then assert `reset` asynchronously → all outputs 0 with no clock edge. After release, header 0x40 gives `osc_init` normally. With `CFG_SEQ_WATCHDOG_EN`: header 0x10 then no data → `err`=1 and IDLE after `WD_LIMIT` cycles.
